// File: rtl/paddle_input_conditioner.sv
// Paddle button conditioner: sync, debounce, press edge, pending move requests per tick.
// Optional auto-repeat is compiled in when INPUT_REPEAT_EN is defined.
module paddle_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 15000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       game_tick,
    output logic [3:0] move_req,
    output logic [3:0] btn_level
);

    localparam int unsigned NB = 4;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NB-1:0] sync1, sync2, stable, stable_q, armed, pend;
    logic [DW-1:0] db_cnt [NB];
    logic [1:0]    warm_cnt;
    logic          warm;
    logic [NB-1:0] press_c, rep_c, evt_c, pend_nxt_c;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("paddle_input_conditioner: cycle parameters must be at least 1");
    end

    // Synchronizers are only trustworthy once both stages have reloaded after reset
    assign warm = (warm_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            warm_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (!warm) warm_cnt <= warm_cnt + 2'd1;
        end
    end

    // Debounce: stable flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // A button is armed only once seen released, so a press held through reset is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            armed    <= '0;
        end else begin
            stable_q <= stable;
            armed    <= armed | ({NB{warm}} & ~stable & ~sync2);
        end
    end

    assign press_c = stable & ~stable_q & armed;

`ifdef INPUT_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt [NB];
    logic [NB-1:0] rep_first;

    // rep_cnt counts cycles since the last press or repeat event while held
    always_comb begin
        rep_c = '0;
        for (int i = 0; i < NB; i++) begin
            if (stable[i] && armed[i] && !press_c[i]) begin
                rep_c[i] = rep_first[i] ? (rep_cnt[i] == RW'(REPEAT_DELAY))
                                        : (rep_cnt[i] == RW'(REPEAT_PERIOD));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_first <= '1;
            for (int i = 0; i < NB; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!stable[i] || !armed[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (press_c[i]) begin
                    rep_cnt[i]   <= RW'(1);
                    rep_first[i] <= 1'b1;
                end else if (rep_c[i]) begin
                    rep_cnt[i]   <= RW'(1);
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i]   <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rep_c = '0;
`endif

    assign evt_c = press_c | rep_c;

    // New events win over the tick clear so a press on the tick cycle is kept
    assign pend_nxt_c = (game_tick ? '0 : pend) | evt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= '0;
            move_req <= '0;
        end else begin
            pend     <= pend_nxt_c;
            move_req <= {pend_nxt_c[3] & ~pend_nxt_c[2], pend_nxt_c[2] & ~pend_nxt_c[3],
                         pend_nxt_c[1] & ~pend_nxt_c[0], pend_nxt_c[0] & ~pend_nxt_c[1]};
        end
    end

    assign btn_level = stable;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Bench for paddle_input_conditioner: directed scenarios plus random buttons vs. a cycle model.
// Build with INPUT_REPEAT_EN defined or undefined; expectations follow the macro.
module tb_paddle_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       game_tick;
    logic [3:0] move_req;
    logic [3:0] btn_level;

    int nvec = 0;
    int nerr = 0;

    paddle_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .game_tick(game_tick),
        .move_req (move_req),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // Reference model: raw delay line, disagreement run lengths, hold ages, pending set
    logic [3:0] m_raw1, m_raw2, m_lvl, m_lvl_prev, m_armed, m_pend, exp_mv, exp_lv;
    int         m_run [4];
    int         m_age [4];
    int         m_since_rst;

    task automatic model(input logic [3:0] raw, input logic tk, input logic rs);
        logic [3:0] press, rep, np, nl;
        if (rs) begin
            m_raw1 = '0; m_raw2 = '0; m_lvl = '0; m_lvl_prev = '0;
            m_armed = '0; m_pend = '0; exp_mv = '0; exp_lv = '0; m_since_rst = 0;
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_age[i] = -1; end
            return;
        end
        rep = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = m_lvl[i] & ~m_lvl_prev[i] & m_armed[i];
`ifdef INPUT_REPEAT_EN
            if (m_lvl[i] && m_armed[i] && !press[i] && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0)
                rep[i] = 1'b1;
`endif
        end
        np = (tk ? 4'b0000 : m_pend) | press | rep;
        m_pend = np;
        exp_mv = {np[3] & ~np[2], np[2] & ~np[3], np[1] & ~np[0], np[0] & ~np[1]};
        for (int i = 0; i < 4; i++) begin
            nl[i] = m_lvl[i];
            if (m_raw2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin nl[i] = ~m_lvl[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
            if (!m_lvl[i] || !m_armed[i]) m_age[i] = -1;
            else if (press[i])            m_age[i] = 1;
            else if (m_age[i] >= 0)       m_age[i]++;
            if (m_since_rst >= 2 && !m_lvl[i] && !m_raw2[i]) m_armed[i] = 1'b1;
        end
        m_raw2 = m_raw1; m_raw1 = raw;
        m_lvl_prev = m_lvl; m_lvl = nl; exp_lv = nl;
        if (m_since_rst < 2) m_since_rst++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, advance model at the edge, compare #1 later
    task automatic step(input logic [3:0] raw, input logic tk, input logic rs);
        btn_raw = raw; game_tick = tk; reset = rs;
        @(posedge clk);
        model(raw, tk, rs);
        #1;
        chk("move_req", 32'(move_req), 32'(exp_mv));
        chk("btn_level", 32'(btn_level), 32'(exp_lv));
    endtask

    int         moves;
    logic [3:0] rraw;
    int         hold [4];
    logic       rtk, rrs;

    initial begin
        btn_raw = '0; game_tick = 1'b0; reset = 1'b1;
        #1;

        // Reset then idle: everything quiet
        repeat (3) step(4'b0000, 1'b0, 1'b1);
        chk("rst_mv", 32'(move_req), 32'h0);
        chk("rst_lvl", 32'(btn_level), 32'h0);
        repeat (8) step(4'b0000, 1'b0, 1'b0);
        chk("idle_mv", 32'(move_req), 32'h0);

        // L1 clean press: level after DB+2 edges, request one edge later, consumed by tick
        repeat (5) step(4'b0001, 1'b0, 1'b0);
        chk("l1_lvl_early", 32'(btn_level), 32'h0);
        step(4'b0001, 1'b0, 1'b0);
        chk("l1_lvl", 32'(btn_level), 32'h1);
        chk("l1_mv_early", 32'(move_req), 32'h0);
        step(4'b0001, 1'b0, 1'b0);
        chk("l1_mv", 32'(move_req), 32'h1);
        repeat (10) step(4'b0001, 1'b0, 1'b0);
        chk("l1_mv_held", 32'(move_req), 32'h1);
        step(4'b0001, 1'b1, 1'b0);
        chk("l1_consumed", 32'(move_req), 32'h0);
        repeat (10) step(4'b0000, 1'b0, 1'b0);

        // R1 glitches shorter than the debounce window never register
        repeat (4) begin
            repeat (3) step(4'b0010, 1'b0, 1'b0);
            repeat (3) step(4'b0000, 1'b0, 1'b0);
            chk("glitch_lvl", 32'(btn_level), 32'h0);
            chk("glitch_mv", 32'(move_req), 32'h0);
        end

        // L2+R2 both pending cancel, both consumed, then R2 alone moves
        repeat (7) step(4'b1100, 1'b0, 1'b0);
        chk("p2_both_lvl", 32'(btn_level), 32'hc);
        chk("p2_both_mv", 32'(move_req), 32'h0);
        step(4'b1100, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b0, 1'b0);
        repeat (7) step(4'b1000, 1'b0, 1'b0);
        chk("p2_r2_mv", 32'(move_req), 32'h8);
        step(4'b1000, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b0, 1'b0);

        // R1 press edge on the tick cycle survives until the following tick
        repeat (6) step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        chk("r1_tick_survive", 32'(move_req), 32'h2);
        repeat (3) step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        chk("r1_tick_consume", 32'(move_req), 32'h0);
        repeat (8) step(4'b0000, 1'b0, 1'b0);

        // L1 long hold with a tick every 4 cycles: count consumed moves
        moves = 0;
        for (int i = 0; i < 80; i++) begin
            if (i % 4 == 0 && move_req[0]) moves++;
            step((i < 56) ? 4'b0001 : 4'b0000, (i % 4 == 0), 1'b0);
        end
`ifdef INPUT_REPEAT_EN
        chk("repeat_moves", 32'(moves), 32'd6);
`else
        chk("repeat_moves", 32'(moves), 32'd1);
`endif

        // Reset mid-hold: no events until release and re-press
        repeat (10) step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        repeat (2) step(4'b0001, 1'b0, 1'b1);
        moves = 0;
        for (int i = 0; i < 60; i++) begin
            if (move_req[0]) moves++;
            step(4'b0001, (i % 4 == 0), 1'b0);
        end
        chk("rst_hold_moves", 32'(moves), 32'd0);
        chk("rst_hold_lvl", 32'(btn_level), 32'h1);
        repeat (10) step(4'b0000, 1'b0, 1'b0);
        repeat (7) step(4'b0001, 1'b0, 1'b0);
        chk("repress_mv", 32'(move_req), 32'h1);
        step(4'b0001, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b0, 1'b0);

        // Random buttons with variable hold lengths, random ticks and rare resets
        rraw = '0;
        for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 12);
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    rraw[b] = ~rraw[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
                end
            end
            rtk = ($urandom_range(0, 5) == 0);
            rrs = ($urandom_range(0, 399) == 0);
            step(rraw, rtk, rrs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/paddle_input_conditioner.md
Name: paddle_input_conditioner

Overview:
Conditions the four raw paddle push-buttons (L1, R1, L2, R2) before they reach the pong game-logic stage. Per button it provides:
- a 2-FF synchronizer
- a debounce filter
- a press-edge detector
- optional auto-repeat

Detected presses are held as pending move requests until the next game tick. This guarantees every press moves the paddle exactly once, however short the press is relative to the slow game clock. It sits between the board pins and the game-logic block; its outputs replace the raw button inputs to that block.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive clk cycles a synced input must disagree with the stable level before the stable level flips (1 ms at 100 MHz); minimum 1.
REPEAT_DELAY, 50000000, cycles a button must be held after its press edge before the first auto-repeat event (REPEAT_EN only).
REPEAT_PERIOD, 15000000, cycles between subsequent auto-repeat events while held (REPEAT_EN only).

Ports:
clk  in  1  system clock (board clock).
reset  in  1  synchronous, active-high.
btn_raw  in  4  asynchronous buttons; bit0=L1, bit1=R1, bit2=L2, bit3=R2.
game_tick  in  1  one-clk-cycle strobe, asserted on the cycle the game logic samples move_req.
move_req  out  4  pending move requests, same bit order; registered level.
btn_level  out  4  debounced stable button levels (for display and diagnostics).

Behaviour:
- Reset (clock and reset as decided: reset is synchronous, active-high; clock is clk):
  - sync FFs, stable levels, debounce counters, repeat counters and pending bits all go to 0.
  - move_req=0 and btn_level=0 on the first edge with reset high.
  - Reset mid-debounce or mid-repeat discards all partial state; a button held through reset release yields no press edge until it is released and pressed again.
- Synchronizer: two flops per bit. The debounce filter sees the input 2 cycles late.
- Debounce, per bit:
  - counter width $clog2(DEBOUNCE_CYCLES+1).
  - If synced == stable, counter clears to 0.
  - Otherwise counter increments; when it reaches DEBOUNCE_CYCLES, stable toggles and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
  - Latency from a clean raw edge to btn_level change: DEBOUNCE_CYCLES+2 cycles.
- Press edge: a 0->1 transition of stable produces a one-cycle internal event. Release produces no event.
- Pending register, per bit:
  - Set on any event (press or repeat).
  - Cleared on the cycle after game_tick, i.e. the bits sampled on the tick cycle are consumed.
  - An event coinciding with game_tick is not lost: the bit remains set after the clear, because set has priority over the tick-clear for that cycle's new event.
  - Multiple events between ticks collapse to one move (saturating, no counting).
- Conflict masking:
  - move_req[L]=pend[L]&~pend[R] and move_req[R]=pend[R]&~pend[L], per player (pairs bits 0/1 and 2/3). This is registered from the masked values.
  - Both pending means no move for that player; both bits are still consumed at the tick.
- Players are fully independent; there are no cross-player interactions.
- Output latency: an event on cycle n gives move_req high on cycle n+1.

Optional Feature:
Macro INPUT_REPEAT_EN.
- Defined: each bit has a repeat counter that starts at the press edge.
  - While stable stays 1, the first repeat event fires REPEAT_DELAY cycles after the press edge, then one every REPEAT_PERIOD cycles.
  - Release (stable=0) clears the counter immediately.
  - Counter width is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- Undefined: no repeat logic is instantiated; exactly one event per debounced press.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Reset 3 cycles, then idle -> move_req=0000 and btn_level=0000 throughout.
2. btn_raw[0] held high from cycle 10 -> btn_level[0]=1 at cycle 16, move_req[0]=1 at cycle 17; game_tick at cycle 30 -> move_req[0]=0 at cycle 31.
3. btn_raw[1] pulsed high for 3 cycles, repeated with 3-cycle low gaps -> btn_level[1] and move_req[1] stay 0.
4. L2 and R2 pressed cleanly, both pending before the tick -> move_req[3:2]=00; after the tick both pendings are cleared; a later R2 press alone -> move_req[3]=1.
5. R1 press edge on the same cycle as game_tick -> move_req[1]=1 survives the tick and is consumed at the following tick.
6. INPUT_REPEAT_EN defined, L1 held 60 cycles past the press edge with a tick every 4 cycles -> events at edge+0, +20, +28, +36, +44, +52 (6 moves); undefined -> 1 move. Reset asserted mid-hold -> no further events until release and re-press.
